// File: rtl/pool_ctrl.sv
// pool_ctrl: tile sequencer for the max_pooling datapath.
// Walks the feature map tile by tile: request tile, pool it, hand the result
// downstream over valid/ready, then move to the next tile origin.
module pool_ctrl #(
  parameter int FM_R      = 6,
  parameter int FM_C      = 6,
  parameter int TILE_R    = 3,
  parameter int TILE_C    = 3,
  parameter int TILE_STEP = 3,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             tile_req,
  input  logic             tile_ack,
  output logic             tile_hold,
  output logic [IDX_W-1:0] tile_row,
  output logic [IDX_W-1:0] tile_col,
  output logic             clr,
  output logic             en_pool,
  output logic             en_pool_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

  localparam int NTR = (FM_R - TILE_R) / TILE_STEP + 1;
  localparam int NTC = (FM_C - TILE_C) / TILE_STEP + 1;
  localparam logic [IDX_W-1:0] NTR_LAST = IDX_W'(NTR - 1);
  localparam logic [IDX_W-1:0] NTC_LAST = IDX_W'(NTC - 1);
  localparam logic [IDX_W-1:0] NTC_W    = IDX_W'(NTC);
  localparam logic [IDX_W-1:0] STEP_W   = IDX_W'(TILE_STEP);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_REQ, S_POOL, S_OUT, S_WR, S_DONE, S_FLUSH
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] row_cnt, col_cnt;
  logic             last_tile, advance;

  assign last_tile = (row_cnt == NTR_LAST) && (col_cnt == NTC_LAST);
  // abort wins over a same-cycle handshake, so the counters must not move
  assign advance   = (state == S_WR) && out_ready && !abort;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // tile counters: zeroed in CLR, stepped on each accepted result, frozen on the last tile
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (state == S_CLR) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (advance && !last_tile) begin
      if (col_cnt == NTC_LAST) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // next state; abort overrides every transition outside IDLE/FLUSH
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && !abort) state_nxt = S_CLR;
      S_CLR:   state_nxt = S_REQ;
      S_REQ:   if (tile_ack) state_nxt = S_POOL;
      S_POOL:  state_nxt = S_OUT;
      S_OUT:   state_nxt = S_WR;
      S_WR:    if (out_ready) state_nxt = last_tile ? S_DONE : S_REQ;
      S_DONE:  state_nxt = S_IDLE;
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE && state != S_FLUSH) state_nxt = S_FLUSH;
  end

  // Moore output decode; enables stay high in WR so max_pooling keeps Y
  always_comb begin
    tile_req    = 1'b0;
    tile_hold   = 1'b0;
    clr         = 1'b0;
    en_pool     = 1'b0;
    en_pool_out = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    case (state)
      S_CLR, S_FLUSH: clr = 1'b1;
      S_REQ:  tile_req = 1'b1;
      S_POOL: begin
        en_pool   = 1'b1;
        tile_hold = 1'b1;
      end
      S_OUT: begin
        en_pool     = 1'b1;
        en_pool_out = 1'b1;
        tile_hold   = 1'b1;
      end
      S_WR: begin
        en_pool     = 1'b1;
        en_pool_out = 1'b1;
        tile_hold   = 1'b1;
        out_valid   = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign tile_row = row_cnt * STEP_W;
  assign tile_col = col_cnt * STEP_W;
  assign out_idx  = row_cnt * NTC_W + col_cnt;

endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl: randomized + directed bench for pool_ctrl with a behavioural model.
module tb_pool_ctrl;

  localparam int IDX_W = 8;
  localparam int FM_R = 6, FM_C = 6, TR = 3, TC = 3, STEP = 3;
  localparam int NTR = (FM_R - TR) / STEP + 1;
  localparam int NTC = (FM_C - TC) / STEP + 1;
  localparam int NT  = NTR * NTC;

  localparam int P_IDLE = 0, P_CLR = 1, P_REQ = 2, P_POOL = 3,
                 P_OUT = 4, P_WR = 5, P_DONE = 6, P_FLUSH = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, tile_ack = 1'b0, out_ready = 1'b0;
  logic tile_req, tile_hold, clr, en_pool, en_pool_out, out_valid, busy, done;
  logic [IDX_W-1:0] tile_row, tile_col, out_idx;

  // second instance: stride 1 on a 4x4 map
  logic start_b = 1'b0, abort_b = 1'b0;
  logic tile_req_b, tile_hold_b, clr_b, en_pool_b, en_pool_out_b, out_valid_b, busy_b, done_b;
  logic [IDX_W-1:0] tile_row_b, tile_col_b, out_idx_b;

  always #5 clk = ~clk;

  pool_ctrl #(.FM_R(FM_R), .FM_C(FM_C), .TILE_R(TR), .TILE_C(TC), .TILE_STEP(STEP), .IDX_W(IDX_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .tile_req(tile_req), .tile_ack(tile_ack), .tile_hold(tile_hold),
    .tile_row(tile_row), .tile_col(tile_col),
    .clr(clr), .en_pool(en_pool), .en_pool_out(en_pool_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .busy(busy), .done(done));

  pool_ctrl #(.FM_R(4), .FM_C(4), .TILE_R(3), .TILE_C(3), .TILE_STEP(1), .IDX_W(IDX_W)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .tile_req(tile_req_b), .tile_ack(1'b1), .tile_hold(tile_hold_b),
    .tile_row(tile_row_b), .tile_col(tile_col_b),
    .clr(clr_b), .en_pool(en_pool_b), .en_pool_out(en_pool_out_b),
    .out_valid(out_valid_b), .out_ready(1'b1), .out_idx(out_idx_b),
    .busy(busy_b), .done(done_b));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model: phase + linear tile number ----------------
  int m_ph = P_IDLE;
  int m_t  = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_ph <= P_IDLE;
      m_t  <= 0;
    end else if (m_ph == P_IDLE) begin
      if (start && !abort) m_ph <= P_CLR;
    end else if (abort && m_ph != P_FLUSH) begin
      m_ph <= P_FLUSH;
    end else begin
      case (m_ph)
        P_CLR:  begin m_t <= 0; m_ph <= P_REQ; end
        P_REQ:  if (tile_ack) m_ph <= P_POOL;
        P_POOL: m_ph <= P_OUT;
        P_OUT:  m_ph <= P_WR;
        P_WR:   if (out_ready) begin
                  if (m_t == NT - 1) m_ph <= P_DONE;
                  else begin m_t <= m_t + 1; m_ph <= P_REQ; end
                end
        default: m_ph <= P_IDLE;
      endcase
    end
  end

  // control bits {req,hold,clr,pool,pool_out,valid,busy,done} required in each phase
  function automatic logic [7:0] exp_ctl(input int ph);
    case (ph)
      P_CLR, P_FLUSH: return 8'b0010_0010;
      P_REQ:          return 8'b1000_0010;
      P_POOL:         return 8'b0101_0010;
      P_OUT:          return 8'b0101_1010;
      P_WR:           return 8'b0101_1110;
      P_DONE:         return 8'b0000_0011;
      default:        return 8'b0000_0000;
    endcase
  endfunction

  // ---------------- compare process + event monitors ----------------
  bit chk_en = 0;
  int cnt_clr, cnt_req, cnt_done, cnt_wr1;
  int q_idx[$], q_row[$], q_col[$];
  int qb_row[$], qb_col[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("ctl", int'({tile_req, tile_hold, clr, en_pool, en_pool_out, out_valid, busy, done}),
            int'(exp_ctl(m_ph)));
      check("tile_row", int'(tile_row), (m_t / NTC) * STEP);
      check("tile_col", int'(tile_col), (m_t % NTC) * STEP);
      check("out_idx",  int'(out_idx),  m_t);
      if (clr)      cnt_clr++;
      if (tile_req) cnt_req++;
      if (done)     cnt_done++;
      if (out_valid && out_idx == 1) cnt_wr1++;
      if (out_valid && out_ready) begin
        q_idx.push_back(int'(out_idx));
        q_row.push_back(int'(tile_row));
        q_col.push_back(int'(tile_col));
      end
      if (out_valid_b) begin
        qb_row.push_back(int'(tile_row_b));
        qb_col.push_back(int'(tile_col_b));
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rnd = 0;
  int ack_delay = 0, stall_idx = -1, stall_len = 0;
  int req_wait = 0, wr_wait = 0;

  // advance one clock and respond to the DUT handshakes
  task automatic tick();
    @(posedge clk);
    #1;
    req_wait = tile_req ? req_wait + 1 : 0;
    wr_wait  = out_valid ? wr_wait + 1 : 0;
    if (rnd) begin
      tile_ack  = ($urandom % 3) == 0;
      out_ready = ($urandom % 2) == 0;
    end else begin
      tile_ack  = tile_req && (req_wait > ack_delay);
      out_ready = out_valid && !(int'(out_idx) == stall_idx && wr_wait <= stall_len);
    end
  endtask

  task automatic clear_mon();
    cnt_clr = 0; cnt_req = 0; cnt_done = 0; cnt_wr1 = 0;
    q_idx.delete(); q_row.delete(); q_col.delete();
  endtask

  // pulse start and run until done, returning the number of clocks taken
  task automatic run_pass(input int budget, output int cycles);
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < budget) begin
      tick();
      cycles++;
    end
    if (!done) check("pass_timeout", 0, 1);
    tick();
  endtask

  task automatic check_seq(input string nm, input int q[$], input int e0, input int e1,
                           input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    check({nm, "_len"}, q.size(), 4);
    for (int i = 0; i < 4; i++) check(nm, (i < q.size()) ? q[i] : -1, e[i]);
  endtask

  initial begin
    int cyc;
    int guard;
    repeat (2) tick();
    chk_en = 1;
    rst = 1'b1;
    tick();

    // reset state
    check("reset_busy", int'(busy), 0);
    check("reset_outs", int'({tile_req, clr, en_pool, out_valid, done, tile_row, tile_col, out_idx}), 0);

    // full pass, immediate ack/ready
    clear_mon();
    run_pass(200, cyc);
    check("pass_cycles", cyc, 18);
    check("pass_clr", cnt_clr, 1);
    check("pass_done", cnt_done, 1);
    check_seq("pass_idx", q_idx, 0, 1, 2, 3);
    check_seq("pass_row", q_row, 0, 0, 3, 3);
    check_seq("pass_col", q_col, 0, 3, 0, 3);

    // back-pressure on tile 1
    clear_mon();
    stall_idx = 1; stall_len = 5;
    run_pass(200, cyc);
    check("bp_wr1_cycles", cnt_wr1, 6);
    check_seq("bp_idx", q_idx, 0, 1, 2, 3);
    stall_idx = -1;

    // upstream stall: ack after 7 extra cycles -> 8 request cycles per tile
    clear_mon();
    ack_delay = 7;
    run_pass(400, cyc);
    check("stall_req_cycles", cnt_req, 4 * 8);
    check("stall_cycles", cyc, 18 + 4 * 7);
    ack_delay = 0;

    // abort in OUT of tile 2
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (!(en_pool_out && !out_valid && out_idx == 2) && guard < 100) begin tick(); guard++; end
    check("abort_reached_out2", int'(guard < 100), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("flush_clr", int'({clr, busy}), 3);
    tick();
    check("flush_idle", int'(busy), 0);
    tick();
    check("abort_no_done", cnt_done, 0);
    clear_mon();
    run_pass(200, cyc);
    check_seq("restart_idx", q_idx, 0, 1, 2, 3);

    // reset mid-WR
    stall_idx = 0; stall_len = 1000;
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin tick(); guard++; end
    check("rst_reached_wr", int'(out_valid), 1);
    rst = 1'b0; tick(); tick(); rst = 1'b1;
    check("rst_mid_outs", int'({tile_req, tile_hold, clr, en_pool, en_pool_out, out_valid, busy, done}), 0);
    check("rst_mid_idx", int'({tile_row, tile_col, out_idx}), 0);
    stall_idx = -1; stall_len = 0;
    tick();

    // stride-1 instance: start+abort in IDLE is ignored, then a normal pass
    start_b = 1'b1; abort_b = 1'b1; tick(); start_b = 1'b0; abort_b = 1'b0;
    tick();
    check("b_start_abort_idle", int'(busy_b), 0);
    qb_row.delete(); qb_col.delete();
    start_b = 1'b1; tick(); start_b = 1'b0;
    guard = 0;
    while (!done_b && guard < 100) begin tick(); guard++; end
    check("b_done", int'(done_b), 1);
    tick();
    check_seq("b_row", qb_row, 0, 0, 1, 1);
    check_seq("b_col", qb_col, 0, 1, 0, 1);

    // randomized traffic with occasional abort / reset
    rnd = 1;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 6) == 0;
      abort = ($urandom % 50) == 0;
      rst   = ($urandom % 400) != 0;
      tick();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
